// File: rtl/pixel_capture_pkg.sv
// Shared types and sizing helpers for the pixel capture front-end.
package pixel_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StLaunch,
    StRun
  } state_e;

  // Length of the network inference window for a given counter width.
  function automatic int unsigned run_cycles(input int unsigned width);
    return (32'd1 << (width + 32'd1)) + 32'd2;
  endfunction

  // Bits needed for a counter that must reach the given terminal value.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal < 32'd2) ? 32'd1 : $clog2(terminal + 32'd1);
  endfunction

endpackage

// File: rtl/pixel_capture_bit_sync.sv
// N-bit multi-flop synchroniser with asynchronous active-low clear.
module bit_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pixel_capture.sv
// Captures a stable pixel column on a trigger edge, pulses start, and freezes the
// pattern for the whole inference window of the downstream network.
module pixel_capture
  import pixel_capture_pkg::*;
#(
  parameter int unsigned Height       = 7,
  parameter int unsigned Width        = 8,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned StableCycles = 16,
  parameter int unsigned ArmTimeout   = 512
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [Height-1:0] pins_i,
  input  logic              trigger_i,
  output logic [Height-1:0] pixels_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              unstable_o
);

  localparam int unsigned RunCycles = run_cycles(Width);
  localparam int unsigned StableW   = cnt_width(StableCycles);
  localparam int unsigned ArmW      = cnt_width(ArmTimeout - 1);
  localparam int unsigned RunW      = cnt_width(RunCycles - 1);

  localparam logic [StableW-1:0] StableMax = StableW'(StableCycles);
  localparam logic [ArmW-1:0]    ArmLast   = ArmW'(ArmTimeout - 1);
  localparam logic [RunW-1:0]    RunLast   = RunW'(RunCycles - 1);

  logic [Height-1:0]  pins_sync, pins_prev_q;
  logic               trig_sync, trig_prev_q;
  logic               trig_edge, pin_change, stable;
  logic [StableW-1:0] stable_cnt_q, stable_cnt_d;
  logic [ArmW-1:0]    arm_cnt_q;
  logic [RunW-1:0]    run_cnt_q;
  state_e             state_q;
  logic [Height-1:0]  pixels_q;
  logic               start_q, busy_q, unstable_q;

  bit_sync #(
    .Width (Height),
    .Stages(SyncStages)
  ) u_pins_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pins_i),
    .q_o   (pins_sync)
  );

  bit_sync #(
    .Width (1),
    .Stages(SyncStages)
  ) u_trig_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (trigger_i),
    .q_o   (trig_sync)
  );

  assign trig_edge  = trig_sync & ~trig_prev_q;
  assign pin_change = (pins_sync != pins_prev_q);
  // A change in the same cycle the count saturates still blocks capture.
  assign stable     = (stable_cnt_q == StableMax) && !pin_change;

  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (pin_change) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != StableMax) begin
      stable_cnt_d = stable_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pins_prev_q  <= '0;
      trig_prev_q  <= 1'b0;
      stable_cnt_q <= '0;
    end else begin
      pins_prev_q  <= pins_sync;
      trig_prev_q  <= trig_sync;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      arm_cnt_q  <= '0;
      run_cnt_q  <= '0;
      pixels_q   <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trig_edge) begin
            state_q    <= StArm;
            busy_q     <= 1'b1;
            unstable_q <= 1'b0;
            arm_cnt_q  <= '0;
          end
        end
        StArm: begin
          if (stable) begin
            pixels_q <= pins_sync;
            start_q  <= 1'b1;
            state_q  <= StLaunch;
          end else if (arm_cnt_q == ArmLast) begin
            unstable_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
          end
        end
        StLaunch: begin
          state_q   <= StRun;
          run_cnt_q <= '0;
        end
        StRun: begin
          if (run_cnt_q == RunLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pixels_o   = pixels_q;
  assign start_o    = start_q;
  assign busy_o     = busy_q;
  assign unstable_o = unstable_q;

endmodule

// File: tb/tb_pixel_capture.sv
// Scoreboard bench for pixel_capture: stimulus queues expected captures, a monitor
// checks every start pulse, its width, the frozen pixels and the busy window.
module tb_pixel_capture;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [6:0] pins_i = 7'h00;
  logic       trigger_i = 1'b0;
  logic [6:0] pixels_o;
  logic       start_o, busy_o, unstable_o;

  int         checks = 0;
  int         errors = 0;
  int         n_starts = 0;
  logic [6:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  pixel_capture #(
    .Height      (7),
    .Width       (8),
    .SyncStages  (2),
    .StableCycles(16),
    .ArmTimeout  (512)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pins_i    (pins_i),
    .trigger_i (trigger_i),
    .pixels_o  (pixels_o),
    .start_o   (start_o),
    .busy_o    (busy_o),
    .unstable_o(unstable_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Cycles from the first sampling edge until start is seen (0 = never).
  task automatic lat(output int k);
    k = 0;
    @(posedge clk_i);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk_i);
      if (start_o === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) break;
    end
    chk(name, 32'(busy_o), 32'd0);
    cyc(1);
  endtask

  initial begin : monitor
    logic [6:0] exp_px, cap;
    int c;
    bit aborted, frozen, extra;
    forever begin
      @(negedge clk_i);
      if (start_o === 1'b1) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          exp_px = exp_q.pop_front();
          chk("start_pixels", 32'(pixels_o), 32'(exp_px));
        end
        cap = pixels_o;
        aborted = 0;
        frozen = 1;
        extra = 0;
        c = 0;
        while (busy_o === 1'b1 && c < 2000) begin
          @(negedge clk_i);
          c++;
          if (!rst_ni) aborted = 1;
          if (c == 1) chk("start_width", 32'(start_o), 32'd0);
          else if (start_o === 1'b1) extra = 1;
          if (busy_o === 1'b1 && pixels_o !== cap) frozen = 0;
        end
        if (!aborted) begin
          chk("busy_len_after_start", 32'(c), 32'd515);
          chk("pixels_frozen", 32'(frozen), 32'd1);
          chk("no_extra_start", 32'(extra), 32'd0);
        end
      end
    end
  end

  initial begin : stimulus
    int k, n0, busy_cnt;

    // Reset state, before any clock edge.
    pins_i = 7'h7f;
    #3;
    chk("rst_pixels", 32'(pixels_o), 32'd0);
    chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_unstable", 32'(unstable_o), 32'd0);
    cyc(3);
    rst_ni = 1'b1;

    // 1: stable pins, basic capture.
    cyc(50);
    exp_q.push_back(7'h7f);
    trigger_i = 1'b1;
    lat(k);
    chk("t1_latency", 32'(k), 32'd4);
    cyc(1);
    wait_idle("t1_idle");
    trigger_i = 1'b0;
    cyc(5);

    // 2: toggling bit 0 delays capture until 16 cycles of stability.
    exp_q.push_back(7'b0101010);
    for (int i = 0; i < 6; i++) begin
      pins_i = (i % 2 == 0) ? 7'b0101011 : 7'b0101010;
      if (i == 0) trigger_i = 1'b1;
      if (i < 5) cyc(10);
    end
    lat(k);
    chk("t2_latency", 32'(k), 32'd20);
    cyc(1);

    // 3: pin changes and trigger pulses during RUN are ignored.
    pins_i = 7'h00;
    trigger_i = 1'b0;
    cyc(4);
    repeat (3) begin
      trigger_i = 1'b1;
      cyc(4);
      trigger_i = 1'b0;
      cyc(4);
    end
    wait_idle("t3_idle");
    cyc(5);
    exp_q.push_back(7'h00);
    trigger_i = 1'b1;
    lat(k);
    chk("t3_latency", 32'(k), 32'd4);
    cyc(1);
    wait_idle("t3_idle2");
    trigger_i = 1'b0;
    cyc(5);

    // 4: never-stable pins time out after 512 ARM cycles.
    n0 = n_starts;
    busy_cnt = 0;
    for (int t = 0; t < 700; t++) begin
      if (t % 5 == 0) pins_i = ((t / 5) % 2 == 0) ? 7'h55 : 7'h2a;
      if (t == 0) trigger_i = 1'b1;
      @(negedge clk_i);
      if (busy_o === 1'b1) busy_cnt++;
      cyc(1);
    end
    chk("t4_arm_cycles", 32'(busy_cnt), 32'd512);
    chk("t4_unstable", 32'(unstable_o), 32'd1);
    chk("t4_busy", 32'(busy_o), 32'd0);
    chk("t4_pixels_kept", 32'(pixels_o), 32'h00);
    chk("t4_no_start", 32'(n_starts - n0), 32'd0);
    trigger_i = 1'b0;
    pins_i = 7'h33;
    cyc(25);
    exp_q.push_back(7'h33);
    trigger_i = 1'b1;
    lat(k);
    chk("t4_retry_latency", 32'(k), 32'd4);
    chk("t4_unstable_cleared", 32'(unstable_o), 32'd0);
    cyc(1);
    wait_idle("t4_idle");
    trigger_i = 1'b0;
    cyc(5);

    // 5: asynchronous reset in the middle of RUN.
    pins_i = 7'h44;
    cyc(25);
    exp_q.push_back(7'h44);
    trigger_i = 1'b1;
    lat(k);
    chk("t5_latency", 32'(k), 32'd4);
    cyc(200);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    trigger_i = 1'b0;
    #1;
    chk("t5_rst_pixels", 32'(pixels_o), 32'd0);
    chk("t5_rst_start", 32'(start_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_unstable", 32'(unstable_o), 32'd0);
    cyc(3);
    rst_ni = 1'b1;
    n0 = n_starts;
    cyc(30);
    chk("t5_idle_busy", 32'(busy_o), 32'd0);
    chk("t5_no_start", 32'(n_starts - n0), 32'd0);
    chk("t5_idle_pixels", 32'(pixels_o), 32'd0);

    // 6: trigger held high across two windows fires only once.
    pins_i = 7'h15;
    cyc(25);
    exp_q.push_back(7'h15);
    n0 = n_starts;
    trigger_i = 1'b1;
    cyc(1100);
    chk("t6_one_start", 32'(n_starts - n0), 32'd1);
    chk("t6_pixels", 32'(pixels_o), 32'h15);
    chk("t6_busy", 32'(busy_o), 32'd0);
    trigger_i = 1'b0;
    cyc(5);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
